// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle layout and register constants.
// Imported by the decode/execute boundary logic and the hazard units.
package pipeline_pkg;

  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_ALU_OP_LSB = 5;
  localparam int CTRL_ALU_OP_MSB = 8;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard equation between a consumer slot and a
// downstream load slot; shared by the ID/EX and MEM-stage hazard logic.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic       i_ld_valid,
  input  logic       i_ld_mem_read,
  input  logic [4:0] i_ld_rd,
  output logic       o_hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ld_rd);
  assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ld_rd);

  // A load into x0 never produces a value anyone can depend on.
  assign o_hazard = i_id_valid && i_ld_valid && i_ld_mem_read &&
                    (i_ld_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, x0 read masking,
// branch flush and a saturating stall counter for debug.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_data_1,
  input  logic [XLEN-1:0]   id_data_2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_data_1,
  output logic [XLEN-1:0]   ex_data_2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_count
);

  import pipeline_pkg::*;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_data_1;
  logic [XLEN-1:0]   r_data_2;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_count;
  logic              w_hazard;
  logic              w_bubble;

  load_use_detect u_load_use_detect (
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ld_valid    (r_valid),
    .i_ld_mem_read (r_ctrl[CTRL_MEM_READ]),
    .i_ld_rd       (r_rd),
    .o_hazard      (w_hazard)
  );

  // Flush and hazard both load a fully zeroed slot; flush just wins the count.
  assign w_bubble = flush || w_hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_ctrl   <= '0;
    end else if (w_bubble) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_ctrl   <= '0;
    end else begin
      r_valid  <= id_valid;
      r_pc     <= id_pc;
      // Register file may return junk for x0; architecturally it reads zero.
      r_data_1 <= (id_rs1 == REG_X0) ? '0 : id_data_1;
      r_data_2 <= (id_rs2 == REG_X0) ? '0 : id_data_2;
      r_imm    <= id_imm;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_rd     <= id_rd;
      r_ctrl   <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_hazard && !flush && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign ex_valid     = r_valid;
  assign ex_pc        = r_pc;
  assign ex_data_1    = r_data_1;
  assign ex_data_2    = r_data_2;
  assign ex_imm       = r_imm;
  assign ex_rs1       = r_rs1;
  assign ex_rs2       = r_rs2;
  assign ex_rd        = r_rd;
  assign ex_ctrl      = r_ctrl;
  assign hazard_stall = w_hazard;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the EX slot and stall counter.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 9;
  localparam int BW     = 1 + 4 * XLEN + 15 + CTRL_W;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic              id_valid, id_uses_rs1, id_uses_rs2, flush;
  logic [XLEN-1:0]   id_pc, id_data_1, id_data_2, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic [CTRL_W-1:0] id_ctrl;

  logic              ex_valid, hazard_stall;
  logic [XLEN-1:0]   ex_pc, ex_data_1, ex_data_2, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [15:0]       stall_count;

  logic              s_valid, s_hazard;
  logic [XLEN-1:0]   s_pc, s_d1, s_d2, s_imm;
  logic [4:0]        s_rs1, s_rs2, s_rd;
  logic [CTRL_W-1:0] s_ctrl;
  logic [1:0]        s_count;

  id_ex_stage dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_data_1(id_data_1), .id_data_2(id_data_2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_data_1(ex_data_1), .ex_data_2(ex_data_2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_data_1(id_data_1), .id_data_2(id_data_2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_data_1(s_d1), .ex_data_2(s_d2), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_ctrl(s_ctrl),
    .hazard_stall(s_hazard), .stall_count(s_count)
  );

  logic [BW-1:0] obs;
  assign obs = {ex_valid, ex_pc, ex_data_1, ex_data_2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_ctrl};

  // Reference model: what the EX slot holds, and how many stall cycles occurred.
  logic              m_valid;
  logic [XLEN-1:0]   m_pc, m_d1, m_d2, m_imm;
  logic [4:0]        m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int                hits;
  int                total = 0;
  int                bad = 0;

  function automatic logic [BW-1:0] exp_bundle();
    return {m_valid, m_pc, m_d1, m_d2, m_imm, m_rs1, m_rs2, m_rd, m_ctrl};
  endfunction

  // EX holds a live load whose destination the decode instruction reads.
  function automatic logic model_hazard();
    logic dep;
    dep = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
    return id_valid && m_valid && m_ctrl[1] && (m_rd != 5'd0) && dep;
  endfunction

  function automatic logic [15:0] exp_cnt();
    return (hits > 65535) ? 16'hFFFF : 16'(hits);
  endfunction

  function automatic logic [1:0] exp_small();
    return (hits > 3) ? 2'd3 : 2'(hits);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
  endtask

  // driver tasks
  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [8:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_data_1 = d1; id_data_2 = d2;
    id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic tick();
    logic h;
    h = model_hazard();
    @(posedge clock);
    if (flush || h) model_clear();
    else begin
      m_valid = id_valid; m_pc = id_pc; m_imm = id_imm;
      m_d1 = (id_rs1 == 0) ? 32'd0 : id_data_1;
      m_d2 = (id_rs2 == 0) ? 32'd0 : id_data_2;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_ctrl = id_valid ? id_ctrl : 9'd0;
    end
    if (h && !flush) hits++;
    #1;
  endtask

  // lw xRD; dependent consumer stalls once, then is captured.
  task automatic load_then_use(input logic [4:0] rd);
    set_id(1, 32'h200, 5'd2, 5'd0, rd, 1, 0, 32'h11, 32'h0, 32'h4, 9'h00B);
    tick();
    set_id(1, 32'h204, rd, 5'd9, 5'd10, 1, 1, 32'h22, 32'h33, 32'h0, 9'h001);
    tick();
    tick();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_ex: got %h want 0", obs); end
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_count); end
    total++;
    if (hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_haz: got %0b want 0", hazard_stall); end
    #11 reset = 1'b0;
  endtask

  task automatic test_capture();
    set_id(1, 32'h100, 5'd3, 5'd4, 5'd7, 1, 1, 32'h1234, 32'h55, 32'hFFFFFFF0, 9'h011);
    tick();
    total++;
    if (ex_data_1 !== 32'h1234) begin bad++; $display("FAIL cap_d1: got %h want 00001234", ex_data_1); end
    total++;
    if (ex_imm !== 32'hFFFFFFF0) begin bad++; $display("FAIL cap_imm: got %h want fffffff0", ex_imm); end
    total++;
    if (ex_ctrl !== 9'h011 || ex_valid !== 1'b1) begin
      bad++; $display("FAIL cap_ctrl: got ctrl=%h v=%0b want ctrl=011 v=1", ex_ctrl, ex_valid);
    end
    total++;
    if (obs !== exp_bundle()) begin bad++; $display("FAIL cap_all: got %h want %h", obs, exp_bundle()); end
  endtask

  task automatic test_load_use();
    set_id(1, 32'h104, 5'd2, 5'd0, 5'd5, 1, 0, 32'h40, 32'h0, 32'h8, 9'h00B);
    tick();
    set_id(1, 32'h108, 5'd1, 5'd5, 5'd6, 1, 1, 32'h7, 32'h8, 32'h0, 9'h001);
    #1;
    total++;
    if (hazard_stall !== 1'b1) begin bad++; $display("FAIL lu_haz: got %0b want 1", hazard_stall); end
    tick();
    total++;
    if (ex_ctrl !== 9'h0 || ex_valid !== 1'b0) begin
      bad++; $display("FAIL lu_bubble: got ctrl=%h v=%0b want ctrl=000 v=0", ex_ctrl, ex_valid);
    end
    total++;
    if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", stall_count); end
    total++;
    if (hazard_stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %0b want 0", hazard_stall); end
    tick();
    total++;
    if (obs !== exp_bundle() || ex_rd !== 5'd6 || ex_valid !== 1'b1) begin
      bad++; $display("FAIL lu_capture: got %h want %h", obs, exp_bundle());
    end
  endtask

  task automatic test_no_false_hazard();
    set_id(1, 32'h300, 5'd1, 5'd0, 5'd0, 1, 0, 32'h1, 32'h0, 32'h0, 9'h00B);
    tick();
    set_id(1, 32'h304, 5'd0, 5'd2, 5'd3, 1, 1, 32'h0, 32'h2, 32'h0, 9'h001);
    #1;
    total++;
    if (hazard_stall !== 1'b0) begin bad++; $display("FAIL nf_x0: got %0b want 0", hazard_stall); end
    tick();
    set_id(1, 32'h308, 5'd1, 5'd0, 5'd5, 1, 0, 32'h1, 32'h0, 32'h0, 9'h00B);
    tick();
    set_id(1, 32'h30C, 5'd7, 5'd5, 5'd8, 1, 0, 32'h3, 32'h4, 32'h0, 9'h011);
    #1;
    total++;
    if (hazard_stall !== 1'b0) begin bad++; $display("FAIL nf_unused: got %0b want 0", hazard_stall); end
    tick();
    total++;
    if (obs !== exp_bundle()) begin bad++; $display("FAIL nf_capture: got %h want %h", obs, exp_bundle()); end
  endtask

  task automatic test_flush();
    set_id(1, 32'h400, 5'd1, 5'd0, 5'd5, 1, 0, 32'h1, 32'h0, 32'h0, 9'h00B);
    tick();
    set_id(1, 32'h404, 5'd5, 5'd6, 5'd7, 1, 1, 32'h9, 32'h9, 32'h0, 9'h001);
    flush = 1'b1;
    #1;
    total++;
    if (hazard_stall !== 1'b1) begin bad++; $display("FAIL fl_haz: got %0b want 1", hazard_stall); end
    tick();
    flush = 1'b0;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL fl_bubble: got %h want 0", obs); end
    total++;
    if (stall_count !== 16'd1) begin bad++; $display("FAIL fl_cnt: got %0d want 1", stall_count); end
  endtask

  task automatic test_x0();
    set_id(1, 32'h500, 5'd0, 5'd0, 5'd4, 1, 1, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 9'h001);
    tick();
    total++;
    if (ex_data_1 !== 32'd0 || ex_data_2 !== 32'd0) begin
      bad++; $display("FAIL x0_mask: got d1=%h d2=%h want 0 0", ex_data_1, ex_data_2);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) load_then_use(5'd5);
    total++;
    if (stall_count !== 16'd5 || ex_valid !== 1'b1) begin
      bad++; $display("FAIL rm_pre: got cnt=%0d v=%0b want cnt=5 v=1", stall_count, ex_valid);
    end
    #2 reset = 1'b1;
    model_clear(); hits = 0;
    #1;
    total++;
    if (obs !== '0 || stall_count !== 16'd0) begin
      bad++; $display("FAIL rm_async: got %h cnt=%0d want 0 cnt=0", obs, stall_count);
    end
    @(negedge clock);
    reset = 1'b0;
    set_id(1, 32'h600, 5'd1, 5'd2, 5'd3, 1, 1, 32'hA, 32'hB, 32'hC, 9'h011);
    tick();
    total++;
    if (obs !== exp_bundle()) begin bad++; $display("FAIL rm_after: got %h want %h", obs, exp_bundle()); end
  endtask

  task automatic test_back_to_back();
    set_id(1, 32'h700, 5'd1, 5'd0, 5'd5, 1, 0, 32'h1, 32'h0, 32'h0, 9'h00B);
    tick();
    set_id(1, 32'h704, 5'd5, 5'd0, 5'd6, 1, 0, 32'h2, 32'h0, 32'h0, 9'h00B);
    #1;
    total++;
    if (hazard_stall !== 1'b1) begin bad++; $display("FAIL b2b_h1: got %0b want 1", hazard_stall); end
    tick();
    tick();
    total++;
    if (obs !== exp_bundle() || ex_rd !== 5'd6) begin bad++; $display("FAIL b2b_ld2: got %h want %h", obs, exp_bundle()); end
    set_id(1, 32'h708, 5'd6, 5'd6, 5'd7, 1, 1, 32'h3, 32'h3, 32'h0, 9'h001);
    #1;
    total++;
    if (hazard_stall !== 1'b1) begin bad++; $display("FAIL b2b_h2: got %0b want 1", hazard_stall); end
    tick();
    total++;
    if (hazard_stall !== 1'b0) begin bad++; $display("FAIL b2b_once: got %0b want 0", hazard_stall); end
    tick();
    total++;
    if (stall_count !== 16'd2) begin bad++; $display("FAIL b2b_cnt: got %0d want 2", stall_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) load_then_use(5'd12);
    total++;
    if (s_count !== 2'd3) begin bad++; $display("FAIL sat_small: got %0d want 3", s_count); end
    total++;
    if (stall_count !== exp_cnt()) begin bad++; $display("FAIL sat_wide: got %0d want %0d", stall_count, exp_cnt()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom_range(0, 9) < 8), $urandom, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), $urandom, $urandom, $urandom, 9'($urandom));
      if ($urandom_range(0, 1) == 1) id_ctrl[1] = 1'b1;
      flush = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (hazard_stall !== model_hazard()) begin
        bad++; $display("FAIL rnd_haz[%0d]: got %0b want %0b", i, hazard_stall, model_hazard());
      end
      tick();
      total++;
      if (obs !== exp_bundle()) begin bad++; $display("FAIL rnd_ex[%0d]: got %h want %h", i, obs, exp_bundle()); end
      total++;
      if (stall_count !== exp_cnt() || s_count !== exp_small()) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, stall_count, s_count, exp_cnt(), exp_small());
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    hits = 0;
    test_reset();
    test_capture();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_x0();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register for the 5-stage RISC-V core, sitting directly downstream of the register file. Each cycle it captures the register-file read data and the decoded instruction fields and forwards them to EX. It also contains load-use hazard detection: on a hazard it stalls fetch/decode and inserts a bubble into EX. It forces reads of x0 to zero, handles branch flushes, and keeps a saturating stall counter for debug.

## Interface
- XLEN, 32, datapath width
- CTRL_W, 9, control bundle width (layout in pipeline_pkg)
- CNT_W, 16, stall counter width
- clock  in  1  pipeline clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  PC of decode instruction
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
- id_data_1, id_data_2  in  XLEN  register-file read data, stable before posedge
- id_imm  in  XLEN  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- flush  in  1  branch/jump resolved taken in EX; kill the decode instruction
- ex_valid  out  1  EX slot valid
- ex_pc, ex_data_1, ex_data_2, ex_imm  out  XLEN  latched operands
- ex_rs1, ex_rs2, ex_rd  out  5 each  latched indices (rs for forwarding unit)
- ex_ctrl  out  CTRL_W  latched control bundle
- hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_count  out  CNT_W  saturating count of hazard stall cycles

## Operation
- Reset (async, immediate): ex_valid=0; all ex_* outputs=0; stall_count=0; hazard_stall then reads 0.
- Control bundle bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [8:5] alu_op.
- Hazard: hazard_stall = id_valid & ex_valid & ex_ctrl[mem_read] & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Each posedge, evaluated in priority order:
  - flush=1: load a bubble (ex_valid=0, ex_ctrl=0, other ex_* fields=0). Flush beats stall.
  - hazard_stall=1: load a bubble. The decode instruction is held upstream and re-presented next cycle.
  - otherwise: capture all id_* fields. ex_valid=id_valid. ex_ctrl=id_valid ? id_ctrl : 0.
- x0 rule: when captured, ex_data_1=0 if id_rs1==0, and ex_data_2=0 if id_rs2==0, regardless of the register-file output.
- Writes from writeback in the same cycle are already visible in id_data_* (the register file writes on posedge and reads on negedge), so no internal bypass.
- stall_count increments by 1 on each posedge where hazard_stall=1 and flush=0. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- Latency: one cycle from id_* to ex_*. All outputs are registered except hazard_stall.
- hazard_stall is valid within the same cycle, derived from the current ex_* registers and the id_* inputs.
- A load-use hazard costs exactly one bubble. After the bubble the load has moved to MEM, so hazard_stall deasserts and the held instruction is captured on the next posedge.
- Back-to-back dependent loads each produce one bubble; stalls never chain beyond one per dependent pair.
- Reset asserted mid-stall clears the bubble and the counter immediately. The first posedge after deassert captures normally.

## Structure
- pipeline_pkg holds:
  - CTRL_W and the control bit indices (CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_MEM_TO_REG, CTRL_ALU_SRC, CTRL_ALU_OP_LSB/MSB)
  - REG_X0 = 5'd0
- Sub-module load_use_detect: purely combinational hazard equation. It is reused later by the hazard unit for the MEM stage.

## Test plan
- Reset: assert reset mid-run with ex_valid=1 and stall_count=5 -> all ex_* outputs=0 and stall_count=0 immediately, without waiting for a clock edge.
- Normal capture: id_valid=1, rs1=3, data_1=0x1234, imm=0xFFFFFFF0, ctrl=0x011 -> next cycle ex_data_1=0x1234, ex_imm=0xFFFFFFF0, ex_ctrl=0x011, ex_valid=1.
- Load-use: EX holds lw x5 (mem_read=1, rd=5); decode holds add using rs2=5 -> hazard_stall=1 for one cycle and an EX bubble (ex_ctrl=0); the add is captured on the following edge; stall_count=1.
- No false hazard:
  - EX holds lw x0 with decode rs1=0 -> hazard_stall=0.
  - EX holds lw x5 with decode id_uses_rs2=0, rs2=5 -> hazard_stall=0.
- Flush beats stall: load-use condition true and flush=1 -> bubble loaded and stall_count unchanged.
- x0 masking and saturation:
  - id_rs1=0 with id_data_1=0xDEADBEEF -> ex_data_1=0.
  - With CNT_W=2, four stall cycles -> stall_count holds at 3.
